// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Upstream fetch stage for the single-cycle RV64 datapath. Holds the program
// counter and a word-addressed instruction memory, and presents one registered
// 32-bit instruction plus its byte address each cycle.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   load_en/addr/data  program-load write port (honoured only in IDLE/HALT)
//   start           leave IDLE/HALT and begin fetching at RESET_PC
//   stall           hold PC and outputs this cycle
//   redirect_valid/redirect_pc  taken branch/jump target from the datapath
//   instr, pc_out, instr_valid  fetched instruction, its address, validity
//   halted          FSM sits in HALT
//   misaligned_err  sticky: redirect target not 4-byte aligned
//   range_err       sticky: PC word index outside the memory
//
// Optional build macro: HALT_ON_ECALL_EN -- when defined, an issued ECALL
// (32'h00000073) halts the fetcher on the following edge unless a redirect
// arrives in that same cycle.

module instr_fetch_unit #(
   parameter int              XLEN     = 64,
   parameter int              DEPTH    = 256,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data,
   input  logic                     start,
   input  logic                     stall,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic [31:0]              instr,
   output logic [XLEN-1:0]          pc_out,
   output logic                     instr_valid,
   output logic                     halted,
   output logic                     misaligned_err,
   output logic                     range_err
);

   localparam int          AW  = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [XLEN-1:0]  pcOut_q, pcOut_d;
   logic             valid_q, valid_d;
   logic             misErr_q, misErr_d;
   logic             rangeErr_q, rangeErr_d;

   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    wordIdx;
   logic [31:0]      memWord;
   logic [XLEN-3:0]  depthVal;
   logic             rangeBad;
   logic             ecallHit;

   assign wordIdx  = pc_q[AW+1:2];
   assign memWord  = mem[wordIdx];
   assign depthVal = (XLEN-2)'(DEPTH);
   // Any PC whose word index lies beyond the memory must not be fetched.
   assign rangeBad = (pc_q[XLEN-1:2] >= depthVal);

`ifdef HALT_ON_ECALL_EN
   localparam logic [31:0] ECALL = 32'h00000073;
   // The ECALL currently on the output was issued last edge; halt now.
   assign ecallHit = valid_q && (instr_q == ECALL);
`else
   assign ecallHit = 1'b0;
`endif

   // Program memory: writable only while the fetcher is not running, never
   // cleared by reset so a loaded program survives a reset.
   always_ff @(posedge clk) begin
      if (load_en && (state_q != RUN)) begin
         mem[load_addr] <= load_data;
      end
   end

   // All architectural state, asynchronously forced to its reset values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= NOP;
         pcOut_q    <= '0;
         valid_q    <= 1'b0;
         misErr_q   <= 1'b0;
         rangeErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pcOut_q    <= pcOut_d;
         valid_q    <= valid_d;
         misErr_q   <= misErr_d;
         rangeErr_q <= rangeErr_d;
      end
   end

   // Next-state logic. In RUN the order is redirect, then the pending ECALL
   // halt, then stall, then the range check guarding an ordinary fetch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pcOut_d    = pcOut_q;
      valid_d    = valid_q;
      misErr_d   = misErr_q;
      rangeErr_d = rangeErr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = RESET_PC;
            end
         end
         HALT: begin
            instr_d = NOP;
            valid_d = 1'b0;
            if (start) begin
               misErr_d   = 1'b0;
               rangeErr_d = 1'b0;
               pc_d       = RESET_PC;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               instr_d = NOP;
               valid_d = 1'b0;
               if (redirect_pc[1:0] != 2'b00) begin
                  misErr_d = 1'b1;
                  state_d  = HALT;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (ecallHit) begin
               state_d = HALT;
               instr_d = NOP;
               valid_d = 1'b0;
            end else if (stall) begin
               state_d = RUN;
            end else if (rangeBad) begin
               rangeErr_d = 1'b1;
               state_d    = HALT;
               instr_d    = NOP;
               valid_d    = 1'b0;
            end else begin
               instr_d = memWord;
               pcOut_d = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + XLEN'(4);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign instr          = instr_q;
   assign pc_out         = pcOut_q;
   assign instr_valid    = valid_q;
   assign halted         = (state_q == HALT);
   assign misaligned_err = misErr_q;
   assign range_err      = rangeErr_q;

endmodule
